// File: rtl/shape_plotter.sv
// Outline plotter: draws a circle or a Reuleaux triangle with a midpoint circle core.
// Emits one candidate pixel per clock during an arc. Candidates that fall off screen or
// outside the arc's region are suppressed on vga_plot, but each one still takes its cycle.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           level request, sampled in idle; also holds done until released
//   mode            0 = circle of radius diameter>>1, 1 = Reuleaux triangle of width diameter
//   colour          draw colour, latched with the other inputs
//   centre_x/_y     shape centre (unsigned)
//   diameter        shape size (unsigned)
//   done            drawing finished; held while start stays high
//   vga_x/_y        pixel coordinate (low bits of the internal signed coordinate)
//   vga_colour      latched colour
//   vga_plot        write strobe, valid in the same cycle as vga_x/vga_y/vga_colour
module shape_plotter #(
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned D_W      = 8,
    parameter int unsigned COLOUR_W = 3,
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [D_W-1:0]      diameter,
    output logic                done,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    localparam int unsigned XY_W = (X_W > Y_W) ? X_W : Y_W;
    // Headroom covers centre + half width + radius and the decision variable.
    localparam int unsigned GW   = ((XY_W > D_W) ? XY_W : D_W) + 5;
    localparam int unsigned PW   = D_W + 10;

    typedef logic signed [GW-1:0] coord_t;

    localparam coord_t ZERO  = '0;
    localparam coord_t ONE   = coord_t'(1);
    localparam coord_t SCR_W = coord_t'(SCREEN_W);
    localparam coord_t SCR_H = coord_t'(SCREEN_H);

    typedef enum logic [2:0] {StIdle, StSetup, StArc, StFlush, StDone} state_t;

    state_t                state;
    logic                  mode_l;
    logic [COLOUR_W-1:0]   colour_l;
    logic [X_W-1:0]        cx_l;
    logic [Y_W-1:0]        cy_l;
    logic [D_W-1:0]        d_l;
    logic [1:0]            arc_idx;
    logic [2:0]            step;
    coord_t                ax, ay, ox, oy, crit;

    coord_t cx_s, cy_s, d_s, half_d, rb, rt, base;
    coord_t arc_ax, arc_ay, arc_r;
    coord_t cand_x, cand_y;
    coord_t ox_nx, oy_nx, crit_nx;
    logic   in_screen, in_region, cand_ok, arc_end, last_arc;

    // Shape geometry from the latched request. 296/1024 and 591/1024 approximate
    // the centroid-to-base and centroid-to-apex distances of an equilateral triangle.
    always_comb begin
        cx_s   = coord_t'(cx_l);
        cy_s   = coord_t'(cy_l);
        d_s    = coord_t'(d_l);
        half_d = d_s >>> 1;
        rb     = coord_t'((PW'(d_l) * PW'(296)) >> 10);
        rt     = coord_t'((PW'(d_l) * PW'(591)) >> 10);
        base   = cy_s + rb;

        arc_ax = cx_s;
        arc_ay = cy_s;
        arc_r  = half_d;
        if (mode_l) begin
            arc_r = d_s;
            case (arc_idx)
                2'd0: begin
                    arc_ax = cx_s;
                    arc_ay = cy_s - rt;
                end
                2'd1: begin
                    arc_ax = cx_s - half_d;
                    arc_ay = base;
                end
                default: begin
                    arc_ax = cx_s + half_d;
                    arc_ay = base;
                end
            endcase
        end
    end

    // Octant candidate for the current step, then clip and region filter.
    always_comb begin
        cand_x = ax + ox;
        cand_y = ay + oy;
        unique case (step)
            3'd0: begin cand_x = ax + ox; cand_y = ay + oy; end
            3'd1: begin cand_x = ax + oy; cand_y = ay + ox; end
            3'd2: begin cand_x = ax - ox; cand_y = ay + oy; end
            3'd3: begin cand_x = ax - oy; cand_y = ay + ox; end
            3'd4: begin cand_x = ax - ox; cand_y = ay - oy; end
            3'd5: begin cand_x = ax - oy; cand_y = ay - ox; end
            3'd6: begin cand_x = ax + ox; cand_y = ay - oy; end
            3'd7: begin cand_x = ax + oy; cand_y = ay - ox; end
        endcase

        in_screen = !cand_x[GW-1] && (cand_x < SCR_W) && !cand_y[GW-1] && (cand_y < SCR_H);

        in_region = 1'b1;
        if (mode_l) begin
            case (arc_idx)
                2'd0:    in_region = (cand_y >= base);
                2'd1:    in_region = (cand_x >= cx_s) && (cand_y <= base);
                default: in_region = (cand_x <= cx_s) && (cand_y <= base);
            endcase
        end
        cand_ok = in_screen && in_region;
    end

    // Midpoint circle step, applied after the eighth octant of an iteration.
    always_comb begin
        oy_nx = oy + ONE;
        if (crit <= ZERO) begin
            ox_nx   = ox;
            crit_nx = crit + (oy_nx <<< 1) + ONE;
        end else begin
            ox_nx   = ox - ONE;
            crit_nx = crit + ((oy_nx - ox_nx) <<< 1) + ONE;
        end
        arc_end  = (oy_nx > ox_nx);
        last_arc = !mode_l || (arc_idx == 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            mode_l     <= 1'b0;
            colour_l   <= '0;
            cx_l       <= '0;
            cy_l       <= '0;
            d_l        <= '0;
            arc_idx    <= '0;
            step       <= '0;
            ax         <= '0;
            ay         <= '0;
            ox         <= '0;
            oy         <= '0;
            crit       <= '0;
        end else begin
            vga_plot <= 1'b0;
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_l   <= mode;
                        colour_l <= colour;
                        cx_l     <= centre_x;
                        cy_l     <= centre_y;
                        d_l      <= diameter;
                        arc_idx  <= 2'd0;
                        state    <= StSetup;
                    end
                end
                StSetup: begin
                    ax    <= arc_ax;
                    ay    <= arc_ay;
                    ox    <= arc_r;
                    oy    <= ZERO;
                    crit  <= ONE - arc_r;
                    step  <= 3'd0;
                    state <= StArc;
                end
                StArc: begin
                    vga_x      <= cand_x[X_W-1:0];
                    vga_y      <= cand_y[Y_W-1:0];
                    vga_colour <= colour_l;
                    vga_plot   <= cand_ok;
                    step       <= step + 3'd1;
                    if (step == 3'd7) begin
                        ox   <= ox_nx;
                        oy   <= oy_nx;
                        crit <= crit_nx;
                        if (arc_end) begin
                            if (last_arc) begin
                                state <= StFlush;
                            end else begin
                                arc_idx <= arc_idx + 2'd1;
                                state   <= StSetup;
                            end
                        end
                    end
                end
                // One cycle for the final registered pixel to be presented before done.
                StFlush: begin
                    done  <= 1'b1;
                    state <= StDone;
                end
                StDone: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_shape_plotter.sv
module tb_shape_plotter;

    localparam int SW = 160;
    localparam int SH = 120;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [2:0] colour;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] diameter;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    shape_plotter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .colour    (colour),
        .centre_x  (centre_x),
        .centre_y  (centre_y),
        .diameter  (diameter),
        .done      (done),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_colour(vga_colour),
        .vga_plot  (vga_plot)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Expected per-cycle output stream, one entry per cycle after the start sample.
    bit exp_pl[$];
    int exp_px[$];
    int exp_py[$];

    // Observations from the most recent draw.
    bit seen[0:SW-1][0:SH-1];
    int n_plots, y_min, y_max, off_ring, off_screen;

    // Reference: each arc is a full midpoint circle traced octant by octant; a cycle
    // of dead time precedes every arc, and a candidate is plotted if on screen and
    // inside the arc's region of the shape.
    task automatic build_model(input bit m, input int cx, input int cy, input int d);
        int ocx[8] = '{1, 0, -1, 0, -1, 0, 1, 0};
        int ocy[8] = '{0, 1, 0, 1, 0, -1, 0, -1};
        int osx[8] = '{0, 1, 0, -1, 0, -1, 0, 1};
        int osy[8] = '{1, 0, 1, 0, -1, 0, -1, 0};
        int rb, rt, h, base, ax, ay, r, ox, oy, crit, x, y;
        bit ok;
        exp_pl.delete(); exp_px.delete(); exp_py.delete();
        rb = (d * 296) / 1024;
        rt = (d * 591) / 1024;
        h = d / 2;
        base = cy + rb;
        exp_pl.push_back(1'b0); exp_px.push_back(0); exp_py.push_back(0);
        for (int a = 0; a < (m ? 3 : 1); a++) begin
            if (!m) begin ax = cx; ay = cy; r = h; end
            else if (a == 0) begin ax = cx; ay = cy - rt; r = d; end
            else if (a == 1) begin ax = cx - h; ay = base; r = d; end
            else begin ax = cx + h; ay = base; r = d; end
            exp_pl.push_back(1'b0); exp_px.push_back(0); exp_py.push_back(0);
            ox = r; oy = 0; crit = 1 - r;
            do begin
                for (int o = 0; o < 8; o++) begin
                    // ocx/ocy weight ox, osx/osy weight oy
                    x = ax + ocx[o] * ox + osx[o] * oy;
                    y = ay + ocy[o] * ox + osy[o] * oy;
                    ok = (x >= 0) && (x < SW) && (y >= 0) && (y < SH);
                    if (m && a == 0) ok = ok && (y >= base);
                    if (m && a == 1) ok = ok && (x >= cx) && (y <= base);
                    if (m && a == 2) ok = ok && (x <= cx) && (y <= base);
                    exp_pl.push_back(ok); exp_px.push_back(x); exp_py.push_back(y);
                end
                oy++;
                if (crit <= 0) crit += 2 * oy + 1;
                else begin ox--; crit += 2 * (oy - ox) + 1; end
            end while (oy <= ox);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with done high, start high.
    task automatic run_draw(input bit m, input int cx, input int cy, input int d,
                            input int col, input int ring);
        int dx, dy, dd;
        build_model(m, cx, cy, d);
        for (int i = 0; i < SW; i++) for (int j = 0; j < SH; j++) seen[i][j] = 1'b0;
        n_plots = 0; y_min = 999; y_max = -1; off_ring = 0; off_screen = 0;
        mode = m; centre_x = 8'(cx); centre_y = 7'(cy); diameter = 8'(d); colour = 3'(col);
        start = 1'b1;
        for (int k = 0; k < exp_pl.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                // Latched already; later input changes must not matter.
                mode = 1'($urandom); centre_x = 8'($urandom); centre_y = 7'($urandom);
                diameter = 8'($urandom); colour = 3'($urandom);
            end
            check_val("done_low", done, 0);
            check_val("plot", vga_plot, exp_pl[k]);
            if (exp_pl[k])
                check_val("pixel", {vga_x, vga_y, vga_colour},
                          32'((exp_px[k] << 10) | (exp_py[k] << 3) | col));
            if (vga_plot === 1'b1) begin
                n_plots++;
                if (vga_x >= SW || vga_y >= SH) off_screen++;
                else seen[vga_x][vga_y] = 1'b1;
                if (int'(vga_y) < y_min) y_min = int'(vga_y);
                if (int'(vga_y) > y_max) y_max = int'(vga_y);
                if (ring > 0) begin
                    dx = int'(vga_x) - cx; dy = int'(vga_y) - cy; dd = dx * dx + dy * dy;
                    if (dd < (ring - 1) * (ring - 1) || dd > (ring + 1) * (ring + 1)) off_ring++;
                end
            end
        end
        @(negedge clk);
        check_val("done_high", done, 1);
        check_val("plot_in_done", vga_plot, 0);
    endtask

    task automatic end_draw();
        start = 1'b0;
        @(negedge clk);
        check_val("done_clear", done, 0);
    endtask

    int t2_plots;

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; colour = '0;
        centre_x = '0; centre_y = '0; diameter = '0;
        #12;
        check_val("rst_done", done, 0);
        check_val("rst_plot", vga_plot, 0);
        check_val("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Circle radius 20
        run_draw(1'b0, 80, 60, 40, 5, 20);
        check_val("c_ring", off_ring, 0);
        check_val("c_100_60", seen[100][60], 1);
        check_val("c_60_60", seen[60][60], 1);
        check_val("c_80_80", seen[80][80], 1);
        check_val("c_80_40", seen[80][40], 1);
        end_draw();

        // Reuleaux width 40: V0=(80,37), base=71. The side arcs meet at x=80 where the
        // radius-40 midpoint arc gives ox=35 at oy=20, so the apex pixel is (80,36).
        run_draw(1'b1, 80, 60, 40, 3, 0);
        t2_plots = n_plots;
        check_val("r_80_77", seen[80][77], 1);
        check_val("r_60_71", seen[60][71], 1);
        check_val("r_100_71", seen[100][71], 1);
        check_val("r_apex", seen[80][36], 1);
        check_val("r_ymax", y_max, 77);
        check_val("r_ymin", y_min, 36);
        end_draw();

        // Clipping at the corners
        run_draw(1'b1, 255, 127, 255, 6, 0);
        check_val("clip_br", off_screen, 0);
        end_draw();
        run_draw(1'b1, 0, 0, 255, 1, 0);
        check_val("clip_tl", off_screen, 0);
        end_draw();
        run_draw(1'b1, 255, 0, 255, 2, 0);
        check_val("clip_tr", off_screen, 0);
        end_draw();
        run_draw(1'b1, 0, 127, 255, 4, 0);
        check_val("clip_bl", off_screen, 0);

        // Holding start keeps done and suppresses a redraw
        repeat (100) begin
            @(negedge clk);
            check_val("hold_done", done, 1);
            check_val("hold_plot", vga_plot, 0);
        end
        end_draw();
        run_draw(1'b0, 30, 30, 20, 7, 10);
        check_val("redraw_ring", off_ring, 0);
        end_draw();

        // Zero diameter: one iteration, eight identical candidates
        run_draw(1'b0, 5, 5, 0, 7, 0);
        check_val("d0_plots", n_plots, 8);
        check_val("d0_pixel", seen[5][5], 1);
        end_draw();

        // Reset in the middle of an arc
        mode = 1'b1; centre_x = 8'd80; centre_y = 7'd60; diameter = 8'd40; colour = 3'd3;
        start = 1'b1;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_plot", vga_plot, 0);
        check_val("mid_rst_xyc", {vga_x, vga_y, vga_colour}, 0);
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_val("in_rst_plot", vga_plot, 0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_val("post_rst_plot", vga_plot, 0);
            check_val("post_rst_done", done, 0);
        end
        run_draw(1'b1, 80, 60, 40, 3, 0);
        check_val("rerun_plots", n_plots, t2_plots);
        end_draw();

        // Random draws against the reference model
        for (int i = 0; i < 8; i++) begin
            run_draw(1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 127),
                     $urandom_range(0, 100), $urandom_range(0, 7), 0);
            check_val("rnd_clip", off_screen, 0);
            end_draw();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
